// File: rtl/seg_display_mux_if.sv
// seg_display_mux_if: game-FSM-to-display bundle; master = value/mode producer, slave = display driver
interface seg_display_mux_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] data;
  logic [1:0] mode;
  logic load;
  logic blinkEn;
  logic blankLZ;
  logic [2:0] brightness;
  logic [DIGITS-1:0] anodeActivate;
  logic [6:0] LED_out;
  logic frameDone;
  modport master (
    output data, mode, load, blinkEn, blankLZ, brightness,
    input anodeActivate, LED_out, frameDone
  );
  modport slave (
    input data, mode, load, blinkEn, blankLZ, brightness,
    output anodeActivate, LED_out, frameDone
  );
endinterface

// File: rtl/seg_display_mux.sv
// seg_display_mux: time-multiplexed, double-buffered common-anode 7-segment driver (hex, YES/NO, blink, leading-zero blanking)
// Ports: fastClk (rising edge), rst (asynchronous, active-high),
//   bus (seg_display_mux_if.slave): data/mode/load from the game FSM, blinkEn, blankLZ,
//   brightness; anodeActivate and LED_out (active-low, registered), frameDone (1-cycle pulse).
// Optional feature: define SEVSEG_DIM_EN to gate each slot's anode by brightness duty.
module seg_display_mux #(
  parameter int DIGITS = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV = 25000000
) (
  input logic fastClk,
  input logic rst,
  seg_display_mux_if.slave bus
);
  localparam int IW = $clog2(DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic [4*DIGITS-1:0] actData, pendData;
  logic [1:0] actMode, pendMode;
  logic pendValid;
  logic [BW-1:0] blinkCnt;
  logic blinkState;
  logic preWrap, boundary, slotEn, lzBlank, lzRun;
  logic isTop, isSecond, isThird;
  logic [3:0] nib;
  logic [6:0] seg;
  assign preWrap = pre == PW'(REFRESH_DIV - 1);
  assign boundary = preWrap && idx == IW'(DIGITS - 1);
  assign isTop = idx == IW'(DIGITS - 1);
  assign isSecond = idx == IW'(DIGITS - 2);
  assign isThird = idx == IW'(DIGITS - 3);
  // Walk from the most significant digit down so lzRun means "this digit and all above are zero".
  always_comb begin
    nib = 4'h0;
    lzBlank = 1'b0;
    lzRun = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lzRun = lzRun & (actData[4*i +: 4] == 4'h0);
      if (idx == IW'(i)) begin
        nib = actData[4*i +: 4];
        lzBlank = lzRun & (i != 0);
      end
    end
  end
  assign seg = actMode == 2'b00 ? (bus.blankLZ && lzBlank ? BLANK : HEX[nib])
             : actMode == 2'b01 ? (isTop ? 7'b0010001 : isSecond ? 7'b0000110 : isThird ? 7'b0010010 : BLANK)
             : actMode == 2'b10 ? (isTop ? 7'b1001000 : isSecond ? 7'b1000000 : BLANK)
             : BLANK;
  // The pre==0 cycle of every slot keeps all anodes dark to hide segment switching ghosts.
`ifdef SEVSEG_DIM_EN
  assign slotEn = pre != '0 && 32'(pre) < (32'(bus.brightness) + 32'd1) * 32'(REFRESH_DIV / 8);
`else
  logic unusedBrightness;
  assign unusedBrightness = ^bus.brightness;
  assign slotEn = pre != '0;
`endif
  always_ff @(posedge fastClk or posedge rst) begin
    if (rst) begin
      pre <= '0;
      idx <= '0;
      actData <= '0;
      actMode <= 2'b11;
      pendData <= '0;
      pendMode <= 2'b11;
      pendValid <= 1'b0;
      blinkCnt <= '0;
      blinkState <= 1'b0;
      bus.anodeActivate <= '1;
      bus.LED_out <= BLANK;
      bus.frameDone <= 1'b0;
    end else begin
      pre <= preWrap ? '0 : pre + 1'b1;
      if (preWrap) idx <= isTop ? '0 : idx + 1'b1;
      // A load on the boundary edge bypasses the pending stage; otherwise pending commits at the boundary.
      if (boundary && bus.load) begin
        actData <= bus.data;
        actMode <= bus.mode;
        pendValid <= 1'b0;
      end else if (boundary && pendValid) begin
        actData <= pendData;
        actMode <= pendMode;
        pendValid <= 1'b0;
      end
      if (bus.load && !boundary) begin
        pendData <= bus.data;
        pendMode <= bus.mode;
        pendValid <= 1'b1;
      end
      if (!bus.blinkEn) begin
        blinkCnt <= '0;
        blinkState <= 1'b0;
      end else if (blinkCnt == BW'(BLINK_DIV - 1)) begin
        blinkCnt <= '0;
        blinkState <= ~blinkState;
      end else blinkCnt <= blinkCnt + 1'b1;
      // Gating with the live blinkEn lets a falling blinkEn restore the display on the very next edge.
      bus.anodeActivate <= (seg == BLANK || !slotEn || (bus.blinkEn && blinkState)) ? '1 : ~(DIGITS'(1) << idx);
      bus.LED_out <= seg;
      bus.frameDone <= boundary;
    end
  end
endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: directed plus random stimulus checked against a time-based display model
module tb_seg_display_mux;
  localparam int D = 4;
  localparam int RD = 8;
  localparam int BD = 64;
  localparam int FRAME = D * RD;
  localparam logic [6:0] BL = 7'b1111111;
  logic fastClk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  int nAssert = 0;
  int nFail = 0;
  int t;
  logic [15:0] actData, pendData;
  logic [1:0] actMode, pendMode;
  bit pendValid;
  int bc;
  bit bs;
  seg_display_mux_if #(.DIGITS(D)) bus ();
  seg_display_mux #(.DIGITS(D), .REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .fastClk(fastClk),
    .rst(rst),
    .bus(bus)
  );
  always #5 fastClk = ~fastClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    nAssert++;
    assert (got === want) else begin
      nFail++;
      $error("FAIL %s t=%0d got %0h want %0h", tag, t, got, want);
    end
  endtask

  task automatic modelReset();
    t = 0;
    actData = '0;
    pendData = '0;
    actMode = 2'b11;
    pendMode = 2'b11;
    pendValid = 0;
    bc = 0;
    bs = 0;
  endtask

  // Glyph the display should show for the slot at scan time t.
  function automatic logic [6:0] expSeg();
    int i;
    logic [3:0] n;
    i = (t / RD) % D;
    n = 4'((actData >> (4 * i)) & 16'hF);
    case (actMode)
      2'b00: return (bus.blankLZ && i > 0 && (actData >> (4 * i)) == 0) ? BL : glyph[n];
      2'b01: return i == D-1 ? 7'b0010001 : i == D-2 ? 7'b0000110 : i == D-3 ? 7'b0010010 : BL;
      2'b10: return i == D-1 ? 7'b1001000 : i == D-2 ? 7'b1000000 : BL;
      default: return BL;
    endcase
  endfunction

  task automatic cycle();
    logic [6:0] s;
    logic [3:0] a;
    bit bnd;
    s = expSeg();
    a = (s == BL || t % RD == 0 || (bus.blinkEn && bs)) ? 4'hF : ~(4'b1 << ((t / RD) % D));
    bnd = (t % FRAME) == FRAME - 1;
    if (bus.load && bnd) begin
      actData = bus.data;
      actMode = bus.mode;
      pendValid = 0;
    end else if (bnd && pendValid) begin
      actData = pendData;
      actMode = pendMode;
      pendValid = 0;
    end
    if (bus.load && !bnd) begin
      pendData = bus.data;
      pendMode = bus.mode;
      pendValid = 1;
    end
    if (!bus.blinkEn) begin
      bc = 0;
      bs = 0;
    end else if (bc == BD - 1) begin
      bc = 0;
      bs = ~bs;
    end else bc++;
    t++;
    @(posedge fastClk);
    #1;
    check("anode", bus.anodeActivate, a);
    check("led", bus.LED_out, s);
    check("frameDone", bus.frameDone, bnd);
    bus.load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic doLoad(input logic [15:0] d, input logic [1:0] m);
    bus.data = d;
    bus.mode = m;
    bus.load = 1'b1;
    cycle();
  endtask

  task automatic runTo(input int phase);
    while (t % FRAME != phase) cycle();
  endtask

  initial begin
    bus.data = '0;
    bus.mode = 2'b00;
    bus.load = 1'b0;
    bus.blinkEn = 1'b0;
    bus.blankLZ = 1'b0;
    bus.brightness = 3'd7;
    modelReset();
    #12;
    check("rst_anode", bus.anodeActivate, 4'hF);
    check("rst_led", bus.LED_out, BL);
    check("rst_frameDone", bus.frameDone, 1'b0);
    @(posedge fastClk);
    #1;
    rst = 1'b0;
    modelReset();
    run(40);
    doLoad(16'h12AF, 2'b00);
    run(2 * FRAME);
    runTo(3 * RD + 2);
    check("slot3_anode", bus.anodeActivate, 4'b0111);
    check("slot3_led", bus.LED_out, 7'b1111001);
    runTo(2);
    check("slot0_anode", bus.anodeActivate, 4'b1110);
    check("slot0_led", bus.LED_out, 7'b0001110);
    bus.blankLZ = 1'b1;
    doLoad(16'h0040, 2'b00);
    run(2 * FRAME);
    bus.blankLZ = 1'b0;
    doLoad(16'h0040, 2'b01);
    run(2 * FRAME);
    doLoad(16'h0000, 2'b10);
    run(2 * FRAME);
    runTo(5);
    doLoad(16'h1111, 2'b00);
    run(5);
    doLoad(16'h2222, 2'b00);
    runTo(FRAME - 1);
    cycle();
    runTo(FRAME - 1);
    doLoad(16'h3333, 2'b00);
    run(2 * FRAME);
    bus.blinkEn = 1'b1;
    for (int k = 0; k < 200 && !bs; k++) cycle();
    check("blink_reached", bs, 1'b1);
    run(20);
    bus.blinkEn = 1'b0;
    run(20);
    bus.blinkEn = 1'b1;
    run(300);
    bus.blinkEn = 1'b0;
    run(20);
    while (t % RD != 3) cycle();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_anode", bus.anodeActivate, 4'hF);
    check("async_rst_led", bus.LED_out, BL);
    @(posedge fastClk);
    #1;
    check("hold_rst_anode", bus.anodeActivate, 4'hF);
    rst = 1'b0;
    modelReset();
    run(2 * FRAME);
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(15) == 0) begin
        for (int j = 0; j < D; j++) bus.data[4*j +: 4] = $urandom_range(1) == 0 ? 4'h0 : 4'($urandom_range(15));
        bus.mode = 2'($urandom_range(3));
        bus.load = 1'b1;
      end
      if ($urandom_range(63) == 0) bus.blankLZ = ~bus.blankLZ;
      if ($urandom_range(199) == 0) bus.blinkEn = ~bus.blinkEn;
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
